// File: rtl/audio_pkg.sv
// Shared types and constants for the WM8731 ADC capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int BIT_CNT_W   = $clog2(SAMPLE_BITS);

  // Left sample occupies the upper half of the packed frame.
  typedef struct packed {
    logic [SAMPLE_BITS-1:0] left;
    logic [SAMPLE_BITS-1:0] right;
  } audio_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SHIFT,
    HOLD
  } cap_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous FIFO of stereo frames with occupancy count.
// Latency: a push is visible on the head one cycle later (no bypass path).
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  audio_frame_t             push_frame,
  input  logic                     pop,
  output audio_frame_t             head_frame,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  audio_frame_t  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // The extra pointer MSB separates a full buffer from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  // Head reads as zero while empty so stale storage never leaks out.
  assign head_frame = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_frame;
  end

endmodule

// File: rtl/audio_adc_capture.sv
// Deserialises the codec I2S ADC stream into {left,right} frames behind a small FIFO.
// Latency: frame valid SYNC_STAGES+3 cycles after the bclk edge carrying the right LSB.
// Backpressure: frames wait in the FIFO; a frame arriving while full is dropped and flagged.
module audio_adc_capture
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_aud_bclk,
  input  logic                          i_aud_adclrck,
  input  logic                          i_aud_adcdat,
  output logic [31:0]                   o_audio_data,
  output logic                          o_audio_valid,
  input  logic                          i_audio_ready,
  output logic                          o_overflow,
  input  logic                          i_clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  // Synchroniser chain, one lane each for {bclk, lrck, dat}.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic bclk_s, lrck_s, dat_s;

  // Strobe stage: registered edge pulse with lrck/dat aligned to it.
  logic bclk_q, bit_stb, lrck_r, dat_r, lrck_prev;
  logic lr_edge;

  // Capture state.
  cap_state_t             state_q, state_d;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d, shift_nxt;
  logic                   chan_q, chan_d;
  logic                   left_ok_q, left_ok_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic                   push_q, push_d;
  audio_frame_t           frame_q, frame_d;

  // FIFO side.
  audio_frame_t head_frame;
  logic         fifo_full, fifo_empty, fifo_pop, drop;

  // Codec signals are asynchronous; every lane gets the same depth so they stay aligned.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {i_aud_bclk, i_aud_adclrck, i_aud_adcdat};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bclk_s = sync_q[SYNC_STAGES-1][2];
  assign lrck_s = sync_q[SYNC_STAGES-1][1];
  assign dat_s  = sync_q[SYNC_STAGES-1][0];

  // Registered rising-edge pulse of bclk; lrck/dat captured alongside it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bclk_q  <= 1'b0;
      bit_stb <= 1'b0;
      lrck_r  <= 1'b0;
      dat_r   <= 1'b0;
    end else begin
      bclk_q  <= bclk_s;
      bit_stb <= bclk_s & ~bclk_q;
      lrck_r  <= lrck_s;
      dat_r   <= dat_s;
    end
  end

  // lrck as seen at the previous strobe, tracked in every state so ALIGN sees real edges.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lrck_prev <= 1'b0;
    end else if (bit_stb) begin
      lrck_prev <= lrck_r;
    end
  end

  // The bit on a channel-change strobe is the I2S delay bit and is never shifted in.
  assign lr_edge   = bit_stb && (lrck_r != lrck_prev);
  assign shift_nxt = {shift_q[SAMPLE_BITS-2:0], dat_r};

  // Capture state and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      chan_q    <= 1'b0;
      left_ok_q <= 1'b0;
      left_q    <= '0;
      push_q    <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      chan_q    <= chan_d;
      left_ok_q <= left_ok_d;
      left_q    <= left_d;
      push_q    <= push_d;
      frame_q   <= frame_d;
    end
  end

  // Next-state: align to a left word, shift 16 MSBs per channel, pair left with right.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    chan_d    = chan_q;
    left_ok_d = left_ok_q;
    left_d    = left_q;
    push_d    = 1'b0;
    frame_d   = frame_q;

    if (!i_enable) begin
      state_d   = IDLE;
      left_ok_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ALIGN;
          left_ok_d = 1'b0;
        end
        ALIGN: begin
          if (lr_edge && !lrck_r) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            chan_d    = 1'b0;
            left_ok_d = 1'b0;
          end
        end
        SHIFT: begin
          if (lr_edge) begin
            // Short word: abandon it and start on the channel now selected.
            cnt_d  = '0;
            chan_d = lrck_r;
            if (!lrck_r) left_ok_d = 1'b0;
          end else if (bit_stb) begin
            shift_d = shift_nxt;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == BIT_CNT_W'(SAMPLE_BITS - 1)) begin
              state_d = HOLD;
              if (!chan_q) begin
                left_d    = shift_nxt;
                left_ok_d = 1'b1;
              end else begin
                // A right word only counts when its left partner completed.
                if (left_ok_q) begin
                  push_d        = 1'b1;
                  frame_d.left  = left_q;
                  frame_d.right = shift_nxt;
                end
                left_ok_d = 1'b0;
              end
            end
          end
        end
        HOLD: begin
          // Bits past the 16th are the codec's extra LSBs; wait for the next channel.
          if (lr_edge) begin
            state_d = SHIFT;
            cnt_d   = '0;
            chan_d  = lrck_r;
            if (!lrck_r) left_ok_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fifo_pop = o_audio_valid && i_audio_ready;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .push       (push_q),
    .push_frame (frame_q),
    .pop        (fifo_pop),
    .head_frame (head_frame),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (o_fifo_level)
  );

  assign o_audio_data  = head_frame;
  assign o_audio_valid = !fifo_empty;
  assign drop          = push_q && fifo_full && !fifo_pop;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: doc/audio_adc_capture.md
# audio_adc_capture

Deserialises the WM8731 codec's I2S ADC stream (codec is bus master) into 32-bit stereo frames for RecordCore's audio port. The block synchronises the codec clocks into the system clock domain and aligns to I2S frame boundaries. Completed frames are buffered in a small FIFO and offered on a ready/valid handshake wired to `record_audio_ready`, `record_audio_data` and `record_audio_valid`.

## Interface
Parameters:
- FIFO_DEPTH, 4, frame buffer depth; power of two, ≥ 2.
- SYNC_STAGES, 2, flip-flop stages per codec input synchroniser; ≥ 2.

Ports:
- i_clk  in  1  system clock; all logic is in this domain.
- i_rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  capture enable, level-sensitive.
- i_aud_bclk  in  1  codec bit clock, asynchronous.
- i_aud_adclrck  in  1  codec ADC LR clock: 0 = left channel, 1 = right channel.
- i_aud_adcdat  in  1  codec ADC serial data, MSB first.
- o_audio_data  out  32  head frame: {left[15:0], right[15:0]}, two's complement, unmodified.
- o_audio_valid  out  1  FIFO not empty.
- i_audio_ready  in  1  consumer accepts the head frame.
- o_overflow  out  1  sticky flag: a frame was dropped.
- i_clear_overflow  in  1  clears o_overflow.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Input synchronisers: bclk, adclrck and adcdat each pass through SYNC_STAGES flops.
- Bit strobe: one-cycle `bit_stb` on each rising edge of the synchronised bclk. All capture logic advances only on `bit_stb`.
- Channel transition: at each `bit_stb`, the current lrck is compared with the lrck latched at the previous `bit_stb`. A difference marks an I2S channel transition; the bit sampled on that strobe is the I2S delay bit and is discarded.
- Capture FSM states:
  - IDLE: entered on reset or when i_enable = 0. Clears `left_ok`.
  - ALIGN: entered when i_enable = 1. Waits for a transition to lrck = 0 (start of a left word).
  - SHIFT: on the transition, the bit counter is set to 0. The next 16 strobes shift adcdat into a 16-bit shift register, MSB first. After bit 15 the FSM moves to HOLD:
    - Left word: latch it into `left_reg` and set `left_ok`.
    - Right word with `left_ok` = 1: push {left_reg, shift} and clear `left_ok`.
    - Right word with `left_ok` = 0: discard it.
  - HOLD: ignore bits (codec words longer than 16 bits are truncated to their 16 MSBs). On the next transition, enter SHIFT for the channel now selected by lrck.
- Short word: a transition that arrives during SHIFT aborts the current word with no latch and no push, then restarts SHIFT for the new channel. If the aborted word was a left word, `left_ok` stays 0.
- i_enable = 0 from any state: go to IDLE on the next cycle. A partial frame is discarded. Frames already in the FIFO are kept and remain drainable.
- FIFO:
  - Show-ahead: o_audio_data is valid whenever o_audio_valid = 1.
  - A pop occurs when o_audio_valid && i_audio_ready.
  - Push while full with no pop in the same cycle: the new frame is dropped and o_overflow is set.
  - Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
  - Push while empty: the frame becomes visible on the following cycle (no bypass).
- o_overflow: set by a drop, cleared by i_clear_overflow. If both occur in the same cycle, set wins.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. Full/empty is distinguished by an extra MSB on each pointer.

## Timing
- Reset values: o_audio_valid = 0, o_audio_data = 0, o_overflow = 0, o_fifo_level = 0. FSM in IDLE, pointers 0, `left_ok` = 0.
- Clock ratio: bclk high and low phases must each be ≥ 2 i_clk periods. This is met by 50 MHz i_clk against codec bclk ≤ 3.072 MHz.
- Latency: with the FIFO empty, o_audio_valid rises exactly SYNC_STAGES + 3 i_clk cycles after the bclk rising edge that carries the right-channel LSB.
- Throughput: one frame per LR period. Handshake pops are possible on back-to-back cycles.
- o_audio_data and o_audio_valid must not change while o_audio_valid = 1 and i_audio_ready = 0, except through reset.

## Structure
- Package `audio_pkg` holds:
  - localparam SAMPLE_BITS = 16.
  - Packed struct `audio_frame_t` {left, right}.
  - Enum `cap_state_t` {IDLE, ALIGN, SHIFT, HOLD}.
- Sub-module `audio_sample_fifo`: parameterised synchronous FIFO of `audio_frame_t` with push/pop/full/empty/level ports.
- The top level contains the synchronisers, edge detector, FSM and overflow flag.

## Test plan
- Basic capture: I2S model sends L = 16'h8001, R = 16'h7FFE with consumer ready = 1. Expect a single valid beat with data 32'h8001_7FFE, SYNC_STAGES + 3 cycles after the right LSB.
- Mid-frame enable: assert i_enable while lrck = 1, mid right word. Expect no frame from the partial word; the first frame pushed is the next complete L/R pair.
- Backpressure and overflow: hold ready = 0 over 6 frames. Expect o_fifo_level = 4, o_overflow = 1, and the frames drained afterwards are frames 1–4 in order. Assert i_clear_overflow and expect o_overflow = 0.
- Full with simultaneous pop: FIFO full, ready pulsed for one cycle coinciding with a push. Expect no overflow, level stays 4, and no frame lost.
- Word length and short word: 24-bit codec words yield their 16 MSBs. A left word cut off after 10 bits by an lrck transition produces no frame for that period.
- Reset during SHIFT: assert i_rst mid-word. Expect all outputs 0 immediately, and after release capture resumes only at the next left-word start.
